// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXEC/[MEM]/WB control FSM around the RV32I decoder.
// Latency 4 cycles (5 for load/store) at zero wait; imem/dmem ack waits and i_stall hold the FSM in place.
module multicycle_sequencer #(
  parameter int unsigned CNT_W    = 32,
  parameter logic [31:0] RESET_IR = 32'h0000_0013
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  output logic             o_imem_req,
  input  logic             i_imem_ack,
  input  logic [31:0]      i_imem_rdata,
  output logic [31:0]      o_instr,
  input  logic             i_rd_wren,
  input  logic             i_mem_wren,
  input  logic [1:0]       i_wb_sel,
  input  logic             i_insn_vld,
  output logic             o_rd_wren,
  output logic             o_pc_wren,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  input  logic             i_dmem_ack,
  output logic             o_illegal,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_instret
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  state_t           state_q, state_d;
  logic             issued_q, issued_d;
  logic             dmem_we_q, dmem_we_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             illegal_q, illegal_d;
  logic             imem_req;
  logic             is_mem;

  assign is_mem = i_mem_wren | (i_wb_sel == 2'b01);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_FETCH;
      issued_q  <= 1'b0;
      dmem_we_q <= 1'b0;
      instr_q   <= RESET_IR;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      issued_q  <= issued_d;
      dmem_we_q <= dmem_we_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    dmem_we_d = dmem_we_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    illegal_d = illegal_q;
    imem_req  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        // Once presented, the request is held regardless of i_stall; reset drops it at once.
        imem_req = i_rst_n & (issued_q | ~i_stall);
        if (imem_req && i_imem_ack) begin
          instr_d  = i_imem_rdata;
          issued_d = 1'b0;
          state_d  = S_DECODE;
        end else if (imem_req) begin
          issued_d = 1'b1;
        end
      end
      S_DECODE: begin
        if (!i_insn_vld) begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_mem) begin
          dmem_we_d = i_mem_wren;
          state_d   = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (i_dmem_ack) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        instret_d = instret_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign o_imem_req = imem_req;
  assign o_instr    = instr_q;
  assign o_dmem_req = (state_q == S_MEM);
  assign o_dmem_we  = (state_q == S_MEM) & dmem_we_q;
  assign o_rd_wren  = (state_q == S_WB) & i_rd_wren;
  assign o_pc_wren  = (state_q == S_WB);
  assign o_illegal  = illegal_q;
  assign o_busy     = (state_q == S_FETCH) ? imem_req : (state_q != S_TRAP);
  assign o_instret  = instret_q;

endmodule
